// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of the 4-entry register file between the ALU
// writeback path (requester 0) and the load-return path (requester 1). Each
// requester owns a one-entry holding buffer. Writes to the same register are
// ordered by age, and writes to different registers take turns round-robin.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req0_valid/addr/data    ALU write request, req0_ready = buffer 0 accepts
//   req1_valid/addr/data    load write request, req1_ready = buffer 1 accepts
//   wen, w_addr, dataIn     register file write port
//   grant_id                source of the current write (valid when wen=1)
//   pend                    one bit per register, set while a full buffer targets it
//   collide_cnt             saturating count of cycles with both buffers full
module regfile_write_arbiter #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic [AW-1:0]   req0_addr,
   input  logic [DW-1:0]   req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [AW-1:0]   req1_addr,
   input  logic [DW-1:0]   req1_data,
   output logic            req1_ready,
   output logic            wen,
   output logic [AW-1:0]   w_addr,
   output logic [DW-1:0]   dataIn,
   output logic            grant_id,
   output logic [(1<<AW)-1:0] pend,
   output logic [7:0]      collide_cnt
);

   logic          full0, full1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] data0, data1;
   // age=0: buffer 0 holds the older entry; age=1: buffer 1 does
   logic          age;
   logic          last_grant;

   logic sel1, grant0, grant1, load0, load1;

   // Pick the buffer to drain. Same-register conflicts follow age so the
   // write-after-write order is kept; otherwise the one not served last wins.
   // Grants are suppressed during reset so no write leaks out that cycle.
   always_comb begin
      sel1 = 1'b0;
      if (full1) begin
         if (!full0)
            sel1 = 1'b1;
         else if (addr0 == addr1)
            sel1 = age;
         else
            sel1 = !last_grant;
      end
      grant1 = !reset & sel1;
      grant0 = !reset & full0 & !sel1;
   end

   // A buffer can take a new entry when it is empty or is being drained now.
   always_comb begin
      req0_ready = !reset & (!full0 | grant0);
      req1_ready = !reset & (!full1 | grant1);
      load0      = req0_valid & req0_ready;
      load1      = req1_valid & req1_ready;
   end

   // Drive the register file port from the granted buffer, zeros when idle.
   always_comb begin
      wen      = grant0 | grant1;
      grant_id = grant1;
      w_addr   = '0;
      dataIn   = '0;
      if (grant1) begin
         w_addr = addr1;
         dataIn = data1;
      end else if (grant0) begin
         w_addr = addr0;
         dataIn = data0;
      end
   end

   // Scoreboard reflects only captured entries; an entry stays pending
   // through its own grant cycle.
   always_comb begin
      pend = '0;
      if (full0)
         pend[addr0] = 1'b1;
      if (full1)
         pend[addr1] = 1'b1;
   end

   // Buffer state, age tracking, round-robin pointer and collision counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         full0       <= 1'b0;
         full1       <= 1'b0;
         addr0       <= '0;
         addr1       <= '0;
         data0       <= '0;
         data1       <= '0;
         age         <= 1'b0;
         last_grant  <= 1'b1;
         collide_cnt <= 8'd0;
      end else begin
         if (load0) begin
            full0 <= 1'b1;
            addr0 <= req0_addr;
            data0 <= req0_data;
         end else if (grant0) begin
            full0 <= 1'b0;
         end

         if (load1) begin
            full1 <= 1'b1;
            addr1 <= req1_addr;
            data1 <= req1_data;
         end else if (grant1) begin
            full1 <= 1'b0;
         end

         // The buffer that was already waiting is older than a newcomer;
         // simultaneous loads treat buffer 0 as older.
         if (load0 && load1)
            age <= 1'b0;
         else if (load0 && full1 && !grant1)
            age <= 1'b1;
         else if (load1 && full0 && !grant0)
            age <= 1'b0;

         if (grant1)
            last_grant <= 1'b1;
         else if (grant0)
            last_grant <= 1'b0;

         if (full0 && full1 && collide_cnt != 8'hFF)
            collide_cnt <= collide_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [1:0] req0_addr, req1_addr;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       wen;
   logic [1:0] w_addr;
   logic [7:0] dataIn;
   logic       grant_id;
   logic [3:0] pend;
   logic [7:0] collide_cnt;

   int checks = 0;
   int errors = 0;

   // Register file written by the arbiter's port
   logic [7:0] rf [4];

   regfile_write_arbiter #(.DW(8), .AW(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .wen(wen), .w_addr(w_addr), .dataIn(dataIn), .grant_id(grant_id),
      .pend(pend), .collide_cnt(collide_cnt)
   );

   always #5 clk = ~clk;

   // Register file model: captures the write port at each rising edge
   always @(posedge clk) begin
      if (wen === 1'b1)
         rf[w_addr] <= dataIn;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_addr = 2'd0; req0_data = 8'h00;
      req1_valid = 1'b0; req1_addr = 2'd0; req1_data = 8'h00;
   endtask

   task automatic apply_reset();
      next_cycle();
      reset = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %b want 0", wen); end
      checks++; if (w_addr !== 2'd0) begin errors++; $display("[TB] FAIL reset_w_addr got %h want 0", w_addr); end
      checks++; if (dataIn !== 8'h00) begin errors++; $display("[TB] FAIL reset_dataIn got %h want 00", dataIn); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_id got %b want 0", grant_id); end
      checks++; if (pend !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pend got %b want 0000", pend); end
      checks++; if (collide_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_collide got %0d want 0", collide_cnt); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b%b want 11", req0_ready, req1_ready); end
   endtask

   task automatic test_single_write();
      apply_reset();
      next_cycle();
      req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 8'h5A;
      @(negedge clk);
      checks++; if (pend !== 4'b0000) begin errors++; $display("[TB] FAIL single_pend_precapture got %b want 0000", pend); end
      checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL single_wen_c1 got %b want 0", wen); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || w_addr !== 2'd2 || dataIn !== 8'h5A || grant_id !== 1'b0)
         begin errors++; $display("[TB] FAIL single_write got wen=%b a=%0d d=%h g=%b want 1 2 5a 0", wen, w_addr, dataIn, grant_id); end
      checks++; if (pend !== 4'b0100) begin errors++; $display("[TB] FAIL single_pend got %b want 0100", pend); end
      next_cycle();
      @(negedge clk);
      checks++; if (pend !== 4'b0000 || wen !== 1'b0) begin errors++; $display("[TB] FAIL single_after got pend=%b wen=%b want 0000 0", pend, wen); end
   endtask

   task automatic test_dual_diff();
      apply_reset();
      next_cycle();
      req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 8'h11;
      req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 8'h22;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b0 || w_addr !== 2'd0 || dataIn !== 8'h11)
         begin errors++; $display("[TB] FAIL dual_first got wen=%b g=%b a=%0d d=%h want 1 0 0 11", wen, grant_id, w_addr, dataIn); end
      checks++; if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL dual_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
      checks++; if (pend !== 4'b0011) begin errors++; $display("[TB] FAIL dual_pend got %b want 0011", pend); end
      next_cycle();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b1 || w_addr !== 2'd1 || dataIn !== 8'h22)
         begin errors++; $display("[TB] FAIL dual_second got wen=%b g=%b a=%0d d=%h want 1 1 1 22", wen, grant_id, w_addr, dataIn); end
      checks++; if (collide_cnt !== 8'd1) begin errors++; $display("[TB] FAIL dual_collide got %0d want 1", collide_cnt); end
      next_cycle();
      @(negedge clk);
      checks++; if (wen !== 1'b0 || collide_cnt !== 8'd1) begin errors++; $display("[TB] FAIL dual_idle got wen=%b cnt=%0d want 0 1", wen, collide_cnt); end
   endtask

   task automatic test_same_addr_order();
      apply_reset();
      next_cycle();
      req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 8'hAA;
      next_cycle();
      idle_inputs();
      req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 8'hBB;
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b1 || dataIn !== 8'hAA) begin errors++; $display("[TB] FAIL order_first got g=%b d=%h want 1 aa", grant_id, dataIn); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b0 || dataIn !== 8'hBB) begin errors++; $display("[TB] FAIL order_second got g=%b d=%h want 0 bb", grant_id, dataIn); end
      next_cycle();
      @(negedge clk);
      checks++; if (rf[3] !== 8'hBB) begin errors++; $display("[TB] FAIL order_final got %h want bb", rf[3]); end
   endtask

   // Both buffers load in the same cycle with the same address while the
   // round-robin pointer favours requester 1: the age rule must win.
   task automatic test_age_tie();
      apply_reset();
      next_cycle();
      req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 8'h10;
      next_cycle();
      req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 8'hBB;
      req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 8'hAA;
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b0 || dataIn !== 8'h10) begin errors++; $display("[TB] FAIL age_first got g=%b d=%h want 0 10", grant_id, dataIn); end
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL age_ready got %b%b want 11", req0_ready, req1_ready); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b0 || w_addr !== 2'd2 || dataIn !== 8'hBB)
         begin errors++; $display("[TB] FAIL age_older got g=%b a=%0d d=%h want 0 2 bb", grant_id, w_addr, dataIn); end
      checks++; if (pend !== 4'b0100) begin errors++; $display("[TB] FAIL age_pend got %b want 0100", pend); end
      next_cycle();
      @(negedge clk);
      checks++; if (wen !== 1'b1 || grant_id !== 1'b1 || dataIn !== 8'hAA) begin errors++; $display("[TB] FAIL age_younger got g=%b d=%h want 1 aa", grant_id, dataIn); end
      next_cycle();
      @(negedge clk);
      checks++; if (rf[2] !== 8'hAA) begin errors++; $display("[TB] FAIL age_final got %h want aa", rf[2]); end
   endtask

   task automatic test_stream_single();
      apply_reset();
      for (int i = 1; i <= 7; i++) begin
         next_cycle();
         if (i <= 5) begin
            req0_valid = 1'b1; req0_addr = 2'(i); req0_data = 8'h30 + 8'(i);
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (i <= 5) begin
            checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream1_ready c%0d got %b want 1", i, req0_ready); end
         end
         if (i >= 2 && i <= 6) begin
            checks++; if (wen !== 1'b1 || w_addr !== 2'(i - 1) || dataIn !== 8'h30 + 8'(i - 1))
               begin errors++; $display("[TB] FAIL stream1_write c%0d got wen=%b a=%0d d=%h want 1 %0d %h", i, wen, w_addr, dataIn, (i - 1) % 4, 8'h30 + 8'(i - 1)); end
         end
         if (i == 7) begin
            checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL stream1_end got wen=%b want 0", wen); end
         end
      end
   endtask

   task automatic test_stream_both();
      logic exp_g;
      apply_reset();
      for (int n = 1; n <= 300; n++) begin
         next_cycle();
         req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 8'h0A;
         req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 8'h0B;
         @(negedge clk);
         if (n >= 2) begin
            exp_g = (n % 2 == 0) ? 1'b0 : 1'b1;
            checks++; if (wen !== 1'b1 || grant_id !== exp_g) begin errors++; $display("[TB] FAIL stream2_grant c%0d got wen=%b g=%b want 1 %b", n, wen, grant_id, exp_g); end
            checks++; if ((exp_g ? req0_ready : req1_ready) !== 1'b0) begin errors++; $display("[TB] FAIL stream2_loser_ready c%0d got 1 want 0", n); end
         end
         if (n == 12) begin
            checks++; if (collide_cnt !== 8'd10) begin errors++; $display("[TB] FAIL stream2_cnt12 got %0d want 10", collide_cnt); end
         end
      end
      checks++; if (collide_cnt !== 8'd255) begin errors++; $display("[TB] FAIL stream2_saturate got %0d want 255", collide_cnt); end
      next_cycle();
      idle_inputs();
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if (collide_cnt !== 8'd255 || wen !== 1'b0) begin errors++; $display("[TB] FAIL stream2_hold got cnt=%0d wen=%b want 255 0", collide_cnt, wen); end
   endtask

   task automatic test_reset_midop();
      apply_reset();
      next_cycle();
      req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 8'h77;
      next_cycle();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_wen got %b want 0", wen); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready got %b%b want 00", req0_ready, req1_ready); end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (pend !== 4'b0000 || wen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after got pend=%b wen=%b want 0000 0", pend, wen); end
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready_after got %b%b want 11", req0_ready, req1_ready); end
      checks++; if (rf[1] !== 8'h0B) begin errors++; $display("[TB] FAIL midreset_rf got %h want 0b", rf[1]); end
   endtask

   initial begin
      for (int r = 0; r < 4; r++) rf[r] = 8'h00;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_write();
      test_dual_diff();
      test_same_addr_order();
      test_age_tie();
      test_stream_single();
      test_stream_both();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
